// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
package regfile_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    localparam reg_addr_t RegZero = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, read per source port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned  RegDepth = 32,
    parameter int unsigned  NumRead  = 2,
    parameter int unsigned  NumWrite = 1,
    parameter bit           Bypass   = 1'b1,
    localparam int unsigned AddrW    = $clog2(RegDepth)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             alloc_en_i,
    input  logic [AddrW-1:0]                 alloc_addr_i,
    input  logic [NumWrite-1:0]              rd_wr_en_i,
    input  logic [NumWrite-1:0][AddrW-1:0]   rd_addr_i,
    input  logic [NumRead-1:0][AddrW-1:0]    rs_addr_i,
    output logic [NumRead-1:0]               rs_busy_o,
    output logic                             busy_any_o
);

    logic [RegDepth-1:0] busy_q;
    logic [RegDepth-1:0] busy_d;

    // Writebacks clear first so a same-cycle alloc of the same register wins:
    // the newer producer is still outstanding.
    always_comb begin
        // NOTE: busy_d takes a full default first so no path leaves it unassigned (no latch).
        busy_d = busy_q;
        for (int j = 0; j < NumWrite; j++) begin
            if (rd_wr_en_i[j]) begin
                busy_d[rd_addr_i[j]] = 1'b0;
            end
        end
        if (alloc_en_i && alloc_addr_i != AddrW'(RegZero)) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_busy_o = '0;
        for (int i = 0; i < NumRead; i++) begin
            rs_busy_o[i] = busy_q[rs_addr_i[i]];
            if (Bypass) begin
                for (int j = 0; j < NumWrite; j++) begin
                    if (rd_wr_en_i[j] && rd_addr_i[j] == rs_addr_i[i]) begin
                        rs_busy_o[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Registered view only; a same-cycle writeback is not reflected here.
    assign busy_any_o = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned  RegWidth = 32,
    parameter int unsigned  RegDepth = 32,
    parameter int unsigned  NumRead  = 2,
    parameter int unsigned  NumWrite = 1,
    parameter bit           Bypass   = 1'b1,
    localparam int unsigned AddrW    = $clog2(RegDepth)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumRead-1:0][AddrW-1:0]     rs_addr_i,
    output logic [NumRead-1:0][RegWidth-1:0]  rs_data_o,
    output logic [NumRead-1:0]                rs_busy_o,
    input  logic [NumWrite-1:0]               rd_wr_en_i,
    input  logic [NumWrite-1:0][AddrW-1:0]    rd_addr_i,
    input  logic [NumWrite-1:0][RegWidth-1:0] rd_data_i,
    input  logic                              alloc_en_i,
    input  logic [AddrW-1:0]                  alloc_addr_i,
    output logic                              busy_any_o
);

    logic [RegDepth-1:0][RegWidth-1:0] regs_q;
    logic [RegDepth-1:0][RegWidth-1:0] regs_d;

    // Ascending port order makes the highest-indexed writer win on a collision.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NumWrite; j++) begin
            if (rd_wr_en_i[j] && rd_addr_i[j] != AddrW'(RegZero)) begin
                regs_d[rd_addr_i[j]] = rd_data_i[j];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the whole array is reset because architectural state must read zero after reset.
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs_data_o = '0;
        for (int i = 0; i < NumRead; i++) begin
            if (rs_addr_i[i] != AddrW'(RegZero)) begin
                rs_data_o[i] = regs_q[rs_addr_i[i]];
                if (Bypass) begin
                    for (int j = 0; j < NumWrite; j++) begin
                        if (rd_wr_en_i[j] && rd_addr_i[j] == rs_addr_i[i]) begin
                            rs_data_o[i] = rd_data_i[j];
                        end
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .RegDepth (RegDepth),
        .NumRead  (NumRead),
        .NumWrite (NumWrite),
        .Bypass   (Bypass)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .rd_wr_en_i   (rd_wr_en_i),
        .rd_addr_i    (rd_addr_i),
        .rs_addr_i    (rs_addr_i),
        .rs_busy_o    (rs_busy_o),
        .busy_any_o   (busy_any_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp in bypass and non-bypass builds.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int NR = 3;
    localparam int NW = 2;
    localparam int NumRandom = 10000;

    logic clk = 1'b0;
    logic rst_n;

    logic [NR-1:0][4:0]  rs_addr;
    logic [NW-1:0]       we;
    logic [NW-1:0][4:0]  wa;
    logic [NW-1:0][31:0] wd;
    logic                alloc_en;
    reg_addr_t           alloc_addr;

    logic [NR-1:0][31:0] data_b1, data_b0;
    logic [NR-1:0]       busy_b1, busy_b0;
    logic                any_b1, any_b0;

    int n_tests = 0;
    int n_fail  = 0;

    reg_data_t model_regs [32];
    bit        model_busy [32];

    always #5 clk = ~clk;

    regfile_mp #(
        .RegWidth (32), .RegDepth (32), .NumRead (NR), .NumWrite (NW), .Bypass (1'b1)
    ) dut_b1 (
        .clk_i (clk), .rst_ni (rst_n), .rs_addr_i (rs_addr), .rs_data_o (data_b1),
        .rs_busy_o (busy_b1), .rd_wr_en_i (we), .rd_addr_i (wa), .rd_data_i (wd),
        .alloc_en_i (alloc_en), .alloc_addr_i (alloc_addr), .busy_any_o (any_b1)
    );

    regfile_mp #(
        .RegWidth (32), .RegDepth (32), .NumRead (NR), .NumWrite (NW), .Bypass (1'b0)
    ) dut_b0 (
        .clk_i (clk), .rst_ni (rst_n), .rs_addr_i (rs_addr), .rs_data_o (data_b0),
        .rs_busy_o (busy_b0), .rd_wr_en_i (we), .rd_addr_i (wa), .rd_data_i (wd),
        .alloc_en_i (alloc_en), .alloc_addr_i (alloc_addr), .busy_any_o (any_b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic idle_inputs();
        we = '0; wa = '0; wd = '0; alloc_en = 1'b0; alloc_addr = '0;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    // Expected read value: architectural state, overridden by a live write when bypassing.
    function automatic reg_data_t exp_data(input logic [4:0] a, input bit byp);
        reg_data_t v;
        if (a == 0) return '0;
        v = model_regs[a];
        if (byp) begin
            for (int j = 0; j < NW; j++) if (we[j] && wa[j] == a) v = wd[j];
        end
        return v;
    endfunction

    function automatic bit exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp) begin
            for (int j = 0; j < NW; j++) if (we[j] && wa[j] == a) return 1'b0;
        end
        return model_busy[a];
    endfunction

    function automatic bit exp_any();
        bit r = 1'b0;
        for (int a = 0; a < 32; a++) r |= model_busy[a];
        return r;
    endfunction

    task automatic model_clock();
        for (int j = 0; j < NW; j++) begin
            if (we[j] && wa[j] != 0) begin
                model_regs[wa[j]] = wd[j];
                model_busy[wa[j]] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != 0) model_busy[alloc_addr] = 1'b1;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            model_regs[a] = '0;
            model_busy[a] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        rs_addr = '0;
        idle_inputs();
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        rs_addr[0] = 5'd5;
        #1;
        check("rst_data_b1", data_b1[0], 32'h0);
        check("rst_data_b0", data_b0[0], 32'h0);
        check("rst_any_b1", 32'(any_b1), 32'h0);
        check("rst_any_b0", 32'(any_b0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // x0 protection
        @(negedge clk);
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h1234;
        alloc_en = 1'b1; alloc_addr = 5'd0; rs_addr[0] = 5'd0;
        #1;
        check("x0_live_b1", data_b1[0], 32'h0);
        check("x0_live_b0", data_b0[0], 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("x0_data_b1", data_b1[0], 32'h0);
        check("x0_data_b0", data_b0[0], 32'h0);
        check("x0_busy_b1", 32'(busy_b1[0]), 32'h0);
        check("x0_busy_b0", 32'(busy_b0[0]), 32'h0);
        check("x0_any_b1", 32'(any_b1), 32'h0);
        check("x0_any_b0", 32'(any_b0), 32'h0);

        // Bypass on x7
        @(negedge clk);
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hA5A5A5A5; rs_addr[0] = 5'd7;
        #1;
        check("byp_same_b1", data_b1[0], 32'hA5A5A5A5);
        check("byp_same_b0", data_b0[0], 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("byp_next_b1", data_b1[0], 32'hA5A5A5A5);
        check("byp_next_b0", data_b0[0], 32'hA5A5A5A5);

        // Two ports write x3: port 1 wins
        @(negedge clk);
        we = 2'b11; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 32'h11; wd[1] = 32'h22;
        rs_addr[1] = 5'd3;
        #1;
        check("conf_same_b1", data_b1[1], 32'h22);
        check("conf_same_b0", data_b0[1], 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("conf_next_b1", data_b1[1], 32'h22);
        check("conf_next_b0", data_b0[1], 32'h22);

        // Scoreboard sequence on x9
        @(negedge clk);
        alloc_en = 1'b1; alloc_addr = 5'd9; rs_addr[2] = 5'd9;
        #1;
        check("sb_alloc_now_b1", 32'(busy_b1[2]), 32'h0);
        check("sb_alloc_now_b0", 32'(busy_b0[2]), 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("sb_alloc_b1", 32'(busy_b1[2]), 32'h1);
        check("sb_alloc_b0", 32'(busy_b0[2]), 32'h1);
        check("sb_any_b1", 32'(any_b1), 32'h1);
        @(negedge clk);
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h55; alloc_en = 1'b1; alloc_addr = 5'd9;
        #1;
        check("sb_wa_mask_b1", 32'(busy_b1[2]), 32'h0);
        check("sb_wa_mask_b0", 32'(busy_b0[2]), 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("sb_wa_data_b1", data_b1[2], 32'h55);
        check("sb_wa_data_b0", data_b0[2], 32'h55);
        check("sb_wa_busy_b1", 32'(busy_b1[2]), 32'h1);
        check("sb_wa_busy_b0", 32'(busy_b0[2]), 32'h1);
        @(negedge clk);
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h66;
        #1;
        check("sb_wb_now_b1", 32'(busy_b1[2]), 32'h0);
        check("sb_wb_now_b0", 32'(busy_b0[2]), 32'h1);
        check("sb_wb_anynow_b1", 32'(any_b1), 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("sb_wb_busy_b0", 32'(busy_b0[2]), 32'h0);
        check("sb_wb_any_b1", 32'(any_b1), 32'h0);
        check("sb_wb_any_b0", 32'(any_b0), 32'h0);
        check("sb_wb_data_b0", data_b0[2], 32'h66);

        // Asynchronous reset mid-operation
        @(negedge clk);
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
        alloc_en = 1'b1; alloc_addr = 5'd6;
        rs_addr[0] = 5'd5; rs_addr[1] = 5'd6;
        @(negedge clk);
        idle_inputs();
        #1;
        check("ar_pre_data", data_b0[0], 32'hDEADBEEF);
        check("ar_pre_busy", 32'(busy_b0[1]), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_data_b1", data_b1[0], 32'h0);
        check("ar_data_b0", data_b0[0], 32'h0);
        check("ar_busy_b0", 32'(busy_b0[1]), 32'h0);
        check("ar_any_b1", 32'(any_b1), 32'h0);
        check("ar_any_b0", 32'(any_b0), 32'h0);

        // Writes while in reset are forwarded but never stored
        @(negedge clk);
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h1111;
        #1;
        check("rw_live_b1", data_b1[0], 32'h1111);
        check("rw_live_b0", data_b0[0], 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rw_drop_b1", data_b1[0], 32'h0);
        check("rw_drop_b0", data_b0[0], 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the reference model
        for (int c = 0; c < NumRandom; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) rs_addr[i] = rand_addr();
            for (int j = 0; j < NW; j++) begin
                we[j] = ($urandom_range(0, 2) != 0);
                wa[j] = rand_addr();
                wd[j] = $urandom;
            end
            alloc_en   = ($urandom_range(0, 1) != 0);
            alloc_addr = rand_addr();
            #1;
            for (int i = 0; i < NR; i++) begin
                check($sformatf("rnd_data_b1[%0d]", i), data_b1[i], exp_data(rs_addr[i], 1'b1));
                check($sformatf("rnd_data_b0[%0d]", i), data_b0[i], exp_data(rs_addr[i], 1'b0));
                check($sformatf("rnd_busy_b1[%0d]", i), 32'(busy_b1[i]), 32'(exp_busy(rs_addr[i], 1'b1)));
                check($sformatf("rnd_busy_b0[%0d]", i), 32'(busy_b0[i]), 32'(exp_busy(rs_addr[i], 1'b0)));
            end
            check("rnd_any_b1", 32'(any_b1), 32'(exp_any()));
            check("rnd_any_b0", 32'(any_b0), 32'(exp_any()));
            model_clock();
        end

        @(negedge clk);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
